// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the load/store stage (master) and memory (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: runs one req/ack data-memory transaction per accepted request,
// aligning and extending load data and flagging misaligned, illegal and timed-out accesses.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_type,
    output logic [31:0] load_data,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       addr_lo_q;
    logic [1:0]       size_q;
    logic             rd_q;
    logic             lu_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [1:0]       etype_q;

    logic             illegal, misaligned, noop, timeout_hit;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [7:0]       lane;
    logic [15:0]      half;
    logic [31:0]      rdata_ext;

    // Checks are prioritised: illegal control, then misalignment, then no-op.
    assign illegal     = (mem_read & mem_write) | ((size == 2'b11) & (mem_read | mem_write));
    assign misaligned  = ((size == 2'b01) & alu_result[0]) |
                         ((size == 2'b10) & (alu_result[1:0] != 2'b00));
    assign noop        = ~mem_read & ~mem_write;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data;
        case (size)
            2'b00: begin
                be_d    = 4'b0001 << alu_result[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_d    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane = 8'(bus.bus_rdata >> {addr_lo_q, 3'b000});
        half = addr_lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (size_q)
            2'b00:   rdata_ext = {{24{~lu_q & lane[7]}}, lane};
            2'b01:   rdata_ext = {{16{~lu_q & half[15]}}, half};
            default: rdata_ext = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        err_type = 2'b00;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = (illegal | misaligned | noop) ? RESP : BUS;
            end
            BUS: begin
                if (bus.bus_ack || timeout_hit) state_d = RESP;
            end
            RESP: begin
                done     = 1'b1;
                err      = err_q;
                err_type = etype_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_q     <= '0;
            size_q        <= '0;
            rd_q          <= 1'b0;
            lu_q          <= 1'b0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            etype_q       <= '0;
            load_data     <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    addr_lo_q <= alu_result[1:0];
                    size_q    <= size;
                    rd_q      <= mem_read;
                    lu_q      <= load_unsigned;
                    cnt_q     <= '0;
                    err_q     <= illegal | misaligned;
                    etype_q   <= illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
                    if (!(illegal || misaligned || noop)) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= mem_write;
                        bus.bus_addr  <= {alu_result[31:2], 2'b00};
                        bus.bus_be    <= be_d;
                        bus.bus_wdata <= wdata_d;
                    end
                end
                BUS: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        err_q       <= 1'b0;
                        etype_q     <= 2'b00;
                        if (rd_q) load_data <= rdata_ext;
                    end else if (timeout_hit) begin
                        bus.bus_req <= 1'b0;
                        err_q       <= 1'b1;
                        etype_q     <= 2'b10;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
